// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver state encoding and the 3-sample majority vote.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser for the serial line followed by a 3-deep history
// whose majority suppresses single-cycle noise spikes.
module uart_rx_sync_vote
  import uart_pkg::*;
(
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Rx_Serial,
  output logic o_Bit
);

  logic       sync_p0;
  logic       sync_p1;
  logic [2:0] vote_p2;

  // Line idles high, so everything resets to 1 to avoid a false start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      vote_p2 <= 3'b111;
    end else begin
      sync_p0 <= i_Rx_Serial;
      sync_p1 <= sync_p0;
      vote_p2 <= {vote_p2[1:0], sync_p1};
    end
  end

  assign o_Bit = majority3(vote_p2);

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width, parity mode and stop-bit count.
// Each bit is sampled mid-period from the voted, synchronised line.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_MODE  = (PARITY == PAR_ODD);

  rx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shadow;
  logic                 par_err;
  logic                 frm_err;
  logic                 par_err_q;
  logic                 rx_bit;
  logic                 bit_tick;

  uart_rx_sync_vote u_sync_vote (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Bit       (rx_bit)
  );

  assign bit_tick = (cnt == LAST_CNT);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      o_Rx_DV     <= 1'b0;
      o_Rx_Data   <= '0;
      par_err_q   <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Busy      <= 1'b0;
    end else begin
      o_Rx_DV     <= 1'b0;
      par_err_q   <= 1'b0;
      o_Frame_Err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          idx     <= '0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
          if (!rx_bit) begin
            state  <= ST_START;
            o_Busy <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            if (!rx_bit) begin
              state <= ST_DATA;
            end else begin
              state  <= ST_IDLE;
              o_Busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            cnt    <= '0;
            // LSB arrives first, so shifting right leaves bit 0 at the bottom.
            shadow <= {rx_bit, shadow[DATA_BITS-1:1]};
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_err <= ((^shadow) ^ rx_bit) != ODD_MODE;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            cnt     <= '0;
            frm_err <= frm_err | ~rx_bit;
            if (idx == LAST_STOP) begin
              idx         <= '0;
              state       <= ST_CLEANUP;
              o_Rx_DV     <= 1'b1;
              o_Rx_Data   <= shadow;
              par_err_q   <= par_err;
              o_Frame_Err <= frm_err | ~rx_bit;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CLEANUP: begin
          // A framing error usually means a break; wait for the line to recover.
          if (frm_err) begin
            state <= ST_WAIT_HIGH;
          end else begin
            state  <= ST_IDLE;
            o_Busy <= 1'b0;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_bit) begin
            state  <= ST_IDLE;
            o_Busy <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_Parity_Err = (PARITY == PAR_NONE) ? 1'b0 : par_err_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) driven with random and
// directed frames, each result compared against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    int         ch;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    int         t;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx;
  logic [2:0] dv, pe, fe, busy;
  logic [7:0] data0, data1;
  logic [6:0] data2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   flag_viol = 0;
  ev_t  evq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]),
    .o_Rx_Data(data0), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Busy(busy[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]),
    .o_Rx_Data(data1), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Busy(busy[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]),
    .o_Rx_Data(data2), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Busy(busy[2]));

  always @(negedge clk) begin
    ev_t e;
    if (dv[0]) begin
      e.ch = 0; e.data = {1'b0, data0}; e.pe = pe[0]; e.fe = fe[0]; e.t = cyc;
      evq.push_back(e);
    end
    if (dv[1]) begin
      e.ch = 1; e.data = {1'b0, data1}; e.pe = pe[1]; e.fe = fe[1]; e.t = cyc;
      evq.push_back(e);
    end
    if (dv[2]) begin
      e.ch = 2; e.data = {2'b00, data2}; e.pe = pe[2]; e.fe = fe[2]; e.t = cyc;
      evq.push_back(e);
    end
    if (((pe | fe) & ~dv) != 3'b000) flag_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int ch, input logic v, input int n);
    rx[ch] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: parity bit chosen so the ones count matches the mode,
  // optionally inverted to provoke a parity error.
  function automatic logic parity_bit(input logic [8:0] d, input int nbits, input int par, input bit bad);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    return ((par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1)) ^ bad;
  endfunction

  function automatic logic model_perr(input logic [8:0] d, input int nbits, input int par, input logic pb);
    int ones = int'(pb);
    if (par == 0) return 1'b0;
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    return (ones % 2) != ((par == 1) ? 1 : 0);
  endfunction

  function automatic logic [8:0] model_data(input logic [8:0] d, input int nbits);
    return d & 9'((1 << nbits) - 1);
  endfunction

  task automatic send_frame(input int ch, input int nbits, input int par, input int nstop,
                            input logic [8:0] d, input bit bad_par, input bit last_stop_low,
                            input int spike_bit, output int t_fall, output logic pb);
    t_fall = cyc;
    pb = parity_bit(d, nbits, par, bad_par);
    hold(ch, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) begin
      if (i == spike_bit) begin
        hold(ch, d[i], HALF);
        hold(ch, ~d[i], 1);
        hold(ch, d[i], HALF - 1);
      end else begin
        hold(ch, d[i], CPB);
      end
    end
    if (par != 0) hold(ch, pb, CPB);
    for (int s = 0; s < nstop; s++)
      hold(ch, (s == nstop - 1 && last_stop_low) ? 1'b0 : 1'b1, CPB);
    rx[ch] = 1'b1;
  endtask

  task automatic run_frame(input string tag, input int ch, input int nbits, input int par,
                           input int nstop, input logic [8:0] d, input bit bad_par,
                           input bit last_stop_low, input int spike_bit);
    int   t_fall, lat, nom;
    logic pb;
    ev_t  e;
    send_frame(ch, nbits, par, nstop, d, bad_par, last_stop_low, spike_bit, t_fall, pb);
    for (int i = 0; i < 4 * CPB && evq.size() == 0; i++) @(negedge clk);
    check({tag, "_dv"}, 32'(evq.size() > 0), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      lat = e.t - t_fall;
      nom = HALF + (nbits + ((par != 0) ? 1 : 0) + nstop) * CPB + 5;
      check({tag, "_chan"}, e.ch, ch);
      check({tag, "_data"}, 32'(e.data), 32'(model_data(d, nbits)));
      check({tag, "_perr"}, 32'(e.pe), 32'(model_perr(d, nbits, par, pb)));
      check({tag, "_ferr"}, 32'(e.fe), 32'(last_stop_low));
      check($sformatf("%s_latency_%0d", tag, lat), 32'(lat >= nom - 1 && lat <= nom + 1), 1);
    end
    hold(ch, 1'b1, CPB);
    check({tag, "_single_dv"}, evq.size(), 0);
    check({tag, "_idle"}, 32'(busy[ch]), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t_fall;
    logic [8:0] d;
    rx = 3'b111;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dv", 32'(dv), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flags", 32'({pe, fe}), 0);
    check("rst_data", 32'({data0, data1, data2}), 0);
    rst_n = 1'b1;
    hold(0, 1'b1, 2 * CPB);

    run_frame("8n1_a5", 0, 8, 0, 1, 9'h0A5, 0, 0, -1);
    run_frame("8e1_07_badpar", 1, 8, 2, 1, 9'h007, 1, 0, -1);

    // Short low glitch on an idle line must be rejected.
    hold(0, 1'b0, 4);
    rx[0] = 1'b1;
    begin
      int waited = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        waited = i;
        if (!busy[0]) break;
      end
      check($sformatf("glitch_busy_clear_%0d", waited), 32'(busy[0]), 0);
    end
    hold(0, 1'b1, 2 * CPB);
    check("glitch_no_dv", evq.size(), 0);

    // Break: line held low for 40 bit times.
    t_fall = cyc;
    hold(0, 1'b0, 40 * CPB);
    check("break_dv_count", evq.size(), 1);
    if (evq.size() > 0) begin
      ev_t e;
      e = evq.pop_front();
      check("break_data", 32'(e.data), 0);
      check("break_ferr", 32'(e.fe), 1);
      check("break_busy", 32'(busy[0]), 1);
    end
    hold(0, 1'b1, 2 * CPB);
    check("break_no_retrigger", evq.size(), 0);
    run_frame("8n1_3c_after_break", 0, 8, 0, 1, 9'h03C, 0, 0, -1);

    run_frame("7o2_55_stop2low", 2, 7, 1, 2, 9'h055, 0, 1, -1);
    run_frame("7o2_55_clean", 2, 7, 1, 2, 9'h055, 0, 0, -1);
    run_frame("8n1_5a_spike", 0, 8, 0, 1, 9'h05A, 0, 0, 3);

    // Reset pulse in the middle of bit 4.
    d = 9'h0C3;
    hold(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(0, d[i], CPB);
    hold(0, d[4], HALF);
    rst_n = 1'b0;
    rx[0] = 1'b1;
    #2;
    check("midrst_dv", 32'(dv[0]), 0);
    check("midrst_busy", 32'(busy[0]), 0);
    check("midrst_data", 32'(data0), 0);
    check("midrst_flags", 32'({pe[0], fe[0]}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(0, 1'b1, 12 * CPB);
    check("midrst_no_dv", evq.size(), 0);
    run_frame("8n1_c3_after_rst", 0, 8, 0, 1, 9'h0C3, 0, 0, -1);

    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("rnd8n1_%0d", k), 0, 8, 0, 1, 9'($urandom_range(0, 255)), 0,
                bit'($urandom_range(0, 1)), -1);
      run_frame($sformatf("rnd8e1_%0d", k), 1, 8, 2, 1, 9'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)), 0, int'($urandom_range(0, 7)));
      run_frame($sformatf("rnd7o2_%0d", k), 2, 7, 1, 2, 9'($urandom_range(0, 127)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), -1);
    end
    run_frame("8n1_zero", 0, 8, 0, 1, 9'h000, 0, 0, -1);

    check("flags_outside_dv", flag_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, clock cycles per bit (12 MHz / 9600); legal 8..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked; legal 1..2.
REQ-005 i_Clock  input  1  sole clock; all logic on rising edge.
REQ-006 i_Rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-008 o_Rx_DV  output  1  one-cycle pulse: frame complete, o_Rx_Data and error flags valid.
REQ-009 o_Rx_Data  output  DATA_BITS  received word, LSB = first data bit.
REQ-010 o_Parity_Err  output  1  parity mismatch; meaningful only while o_Rx_DV=1.
REQ-011 o_Frame_Err  output  1  stop bit sampled low; meaningful only while o_Rx_DV=1.
REQ-012 o_Busy  output  1  high in every state except IDLE.

Function
REQ-013 i_Rx_Serial shall pass through a 2-flop synchroniser, then a 3-deep shift register; the sampled bit value is the majority of the three entries.
REQ-014 States: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
REQ-015 IDLE: counter and bit index held at 0; on synchronised line = 0 go to START.
REQ-016 START: counter increments each cycle; at count = CLKS_PER_BIT/2 (integer division), voted sample 0 -> counter 0, go DATA; voted sample 1 -> IDLE (glitch rejected, no DV).
REQ-017 DATA: sample when counter = CLKS_PER_BIT-1, then counter 0; bit stored at o_Rx_Data[index]; after DATA_BITS samples go PARITY if PARITY != 0, else STOP.
REQ-018 PARITY: one sample at same point; Parity_Err = (XOR of data bits XOR sampled bit) != (PARITY==1 ? 1 : 0).
REQ-019 STOP: STOP_BITS samples at same point; Frame_Err set if any stop sample is 0.
REQ-020 On the cycle after the final stop sample: o_Rx_DV=1 for exactly one cycle with o_Rx_Data, o_Parity_Err, o_Frame_Err valid; state CLEANUP.
REQ-021 o_Rx_DV shall pulse for every completed frame, including error frames and all-zero data.
REQ-022 CLEANUP lasts one cycle; next state IDLE if Frame_Err=0, else WAIT_HIGH.
REQ-023 WAIT_HIGH: remain until voted line = 1, then IDLE (no re-trigger on held-low break).
REQ-024 o_Rx_Data shall be updated only in the o_Rx_DV cycle (shadow register internally) and hold until the next o_Rx_DV.
REQ-025 Error flags shall be 0 whenever o_Rx_DV=0; o_Parity_Err tied 0 when PARITY=0.
REQ-026 Counter width $clog2(CLKS_PER_BIT)+1; no wrap within any bit period.
REQ-027 Latency: o_Rx_DV asserts (0.5 + DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT + 5 +/- 1 cycles after the line falling edge, P = 1 if parity enabled.

Reset
REQ-028 Reset asserted: state IDLE; counter, index, shadow data 0; sync/vote flops 1; all outputs 0.
REQ-029 Reset mid-frame aborts the frame without o_Rx_DV; after release, reception restarts on the next falling edge.

Structure
REQ-030 Package uart_pkg: parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and state encoding.
REQ-031 Sub-module uart_rx_sync_vote: synchroniser + 3-sample majority; ports i_Clock, i_Rst_n, i_Rx_Serial, o_Bit.

Verification (CLKS_PER_BIT=16)
REQ-032 8N1, byte 0xA5 -> single DV pulse, o_Rx_Data=0xA5, both errors 0, latency per REQ-027.
REQ-033 8E1, byte 0x07 sent with parity bit 0 -> DV, data 0x07, o_Parity_Err=1, o_Frame_Err=0.
REQ-034 Low glitch of 4 cycles on idle line -> no DV, o_Busy returns 0 within 10 cycles.
REQ-035 Line held low 40 bit times -> one DV with data 0x00, o_Frame_Err=1; no further DV until line high, then 0x3C frame received correctly.
REQ-036 7O2, 0x55 with second stop bit 0 -> DV, o_Frame_Err=1; single-cycle noise spike mid-bit in a 0x5A frame -> data 0x5A.
REQ-037 i_Rst_n pulsed low during bit 4 -> outputs 0, no DV; next frame 0xC3 received correctly.
